// File: rtl/text_overlay_pkg.sv
// Shared constants and types for the text overlay and its glyph ROM.
// Glyph geometry, glyph codes and pipeline latency live here so sub-blocks agree.
package text_overlay_pkg;

    localparam int GLYPH_W   = 16;
    localparam int GLYPH_H   = 24;
    localparam int GLYPH_NUM = 18;
    localparam int LAT       = 3;

    localparam int COL_W  = $clog2(GLYPH_W);
    localparam int ROW_W  = $clog2(GLYPH_H);
    localparam int CELL   = GLYPH_W * GLYPH_H;
    localparam int CELL_W = $clog2(CELL);

    localparam int CH_0     = 0;
    localparam int CH_1     = 1;
    localparam int CH_2     = 2;
    localparam int CH_3     = 3;
    localparam int CH_4     = 4;
    localparam int CH_5     = 5;
    localparam int CH_6     = 6;
    localparam int CH_7     = 7;
    localparam int CH_8     = 8;
    localparam int CH_9     = 9;
    localparam int CH_F     = 10;
    localparam int CH_P     = 11;
    localparam int CH_G     = 12;
    localparam int CH_A     = 13;
    localparam int CH_T     = 14;
    localparam int CH_E     = 15;
    localparam int CH_S     = 16;
    localparam int CH_BLANK = 17;

    typedef struct packed {
        logic        de;
        logic        vs;
        logic        win;
        logic [23:0] rgb;
    } meta_t;

endpackage

// File: rtl/glyph_rom.sv
// Glyph bitmap ROM: GLYPH_NUM cells of GLYPH_W x GLYPH_H bits, MSB = top-left.
// Latency 1 cycle (registered bit); codes >= GLYPH_NUM read as blank.
// No backpressure: one lookup per clock.
module glyph_rom
    import text_overlay_pkg::*;
#(
    parameter int CODE_W = 5
) (
    input  logic              pixel_clk,
    input  logic              rst,
    input  logic [CODE_W-1:0] code,
    input  logic [ROW_W-1:0]  row,
    input  logic [COL_W-1:0]  col,
    output logic              glyph_bit
);

    // 5x7 master font, each font dot drawn as a 2x3 block offset (2,1) inside the cell.
    localparam int FONT_X0 = 2;
    localparam int FONT_Y0 = 1;
    localparam int FONT_SX = 2;
    localparam int FONT_SY = 3;

    localparam logic [34:0] FONT [GLYPH_NUM] = '{
        35'b01110_10001_10011_10101_11001_10001_01110,  // 0
        35'b00100_01100_00100_00100_00100_00100_01110,  // 1
        35'b01110_10001_00001_00010_00100_01000_11111,  // 2
        35'b11110_00001_00001_01110_00001_00001_11110,  // 3
        35'b00010_00110_01010_10010_11111_00010_00010,  // 4
        35'b11111_10000_11110_00001_00001_10001_01110,  // 5
        35'b00110_01000_10000_11110_10001_10001_01110,  // 6
        35'b11111_00001_00010_00100_01000_01000_01000,  // 7
        35'b01110_10001_10001_01110_10001_10001_01110,  // 8
        35'b01110_10001_10001_01111_00001_00010_01100,  // 9
        35'b11111_10000_10000_11110_10000_10000_10000,  // F
        35'b11110_10001_10001_11110_10000_10000_10000,  // P
        35'b01110_10001_10000_10111_10001_10001_01111,  // G
        35'b01110_10001_10001_11111_10001_10001_10001,  // A
        35'b11111_00100_00100_00100_00100_00100_00100,  // T
        35'b11111_10000_10000_11110_10000_10000_11111,  // E
        35'b01111_10000_10000_01110_00001_00001_11110,  // S
        35'b00000_00000_00000_00000_00000_00000_00000   // blank
    };

    function automatic logic [CELL-1:0] expand(input logic [34:0] f);
        logic [CELL-1:0] m;
        int              fi;
        m = '0;
        for (int r = 0; r < GLYPH_H; r++) begin
            for (int c = 0; c < GLYPH_W; c++) begin
                if (r >= FONT_Y0 && r < FONT_Y0 + 7 * FONT_SY &&
                    c >= FONT_X0 && c < FONT_X0 + 5 * FONT_SX) begin
                    fi = 34 - (((r - FONT_Y0) / FONT_SY) * 5 + (c - FONT_X0) / FONT_SX);
                    m[CELL_W'(CELL - 1 - (r * GLYPH_W + c))] = f[6'(fi)];
                end
            end
        end
        return m;
    endfunction

    logic [CELL-1:0]   bitmap [GLYPH_NUM];
    logic [CELL_W-1:0] bit_idx;

    for (genvar g = 0; g < GLYPH_NUM; g++) begin : g_glyph
        assign bitmap[g] = expand(FONT[g]);
    end

    assign bit_idx = CELL_W'(CELL - 1 - (int'(row) * GLYPH_W + int'(col)));

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            glyph_bit <= 1'b0;
        end else if (int'(code) < GLYPH_NUM) begin
            glyph_bit <= bitmap[code][bit_idx];
        end else begin
            glyph_bit <= 1'b0;
        end
    end

endmodule

// File: rtl/text_overlay.sv
// Text overlay: composites a writable glyph string onto the video stream.
// Latency LAT=3 cycles on all outputs; sync/enable delayed to match.
// No backpressure: accepts and emits one pixel per clock, never stalls.
module text_overlay
    import text_overlay_pkg::*;
#(
    parameter int MAX_CHARS = 32,
    parameter int CODE_W    = 5,
    parameter int DEF_X     = 10,
    parameter int DEF_Y     = 10,
    localparam int SLOT_W   = $clog2(MAX_CHARS)
) (
    input  logic              pixel_clk,
    input  logic              rst,
    input  logic [11:0]       pixel_x,
    input  logic [11:0]       pixel_y,
    input  logic              pixel_de_in,
    input  logic              pixel_vs_in,
    input  logic [23:0]       pixel_data_in,
    input  logic [23:0]       front_colour,
    input  logic [23:0]       back_colour,
    input  logic              transparent,
    input  logic              scale2,
    input  logic [11:0]       pos_x,
    input  logic [11:0]       pos_y,
    input  logic [SLOT_W:0]   str_len,
    input  logic              wr_en,
    input  logic [SLOT_W-1:0] wr_addr,
    input  logic [CODE_W-1:0] wr_code,
    output logic              pixel_de_out,
    output logic              pixel_vs_out,
    output logic              front_de,
    output logic [23:0]       pixel_data_out
);

    logic              vs_d;
    logic [11:0]       sh_x;
    logic [11:0]       sh_y;
    logic [SLOT_W:0]   sh_len;
    logic              sh_scale;

    // Geometry is frozen per frame: shadow registers only move on the vsync rising edge.
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            vs_d     <= 1'b0;
            sh_x     <= 12'(DEF_X);
            sh_y     <= 12'(DEF_Y);
            sh_len   <= '0;
            sh_scale <= 1'b0;
        end else begin
            vs_d <= pixel_vs_in;
            if (pixel_vs_in && !vs_d) begin
                sh_x     <= pos_x;
                sh_y     <= pos_y;
                sh_len   <= str_len;
                sh_scale <= scale2;
            end
        end
    end

    logic [12:0]       dx;
    logic [12:0]       dy;
    logic [12:0]       win_w;
    logic [12:0]       win_h;
    logic [11:0]       dxs;
    logic              in_win;
    logic [SLOT_W-1:0] slot_c;
    logic [COL_W-1:0]  col_c;
    logic [ROW_W-1:0]  row_c;
    meta_t             m0;

    assign dx     = {1'b0, pixel_x} - {1'b0, sh_x};
    assign dy     = {1'b0, pixel_y} - {1'b0, sh_y};
    assign win_w  = 13'(int'(sh_len) * GLYPH_W * (sh_scale ? 2 : 1));
    assign win_h  = sh_scale ? 13'(2 * GLYPH_H) : 13'(GLYPH_H);
    assign in_win = pixel_de_in & ~dx[12] & ~dy[12] & (dx < win_w) & (dy < win_h);
    assign dxs    = sh_scale ? dx[12:1] : dx[11:0];
    assign row_c  = sh_scale ? dy[ROW_W:1] : dy[ROW_W-1:0];

    // GLYPH_W need not be a power of two: slot is the largest k with k*GLYPH_W <= dxs.
    always_comb begin
        slot_c = '0;
        col_c  = COL_W'(dxs);
        for (int k = 1; k < MAX_CHARS; k++) begin
            if (int'(dxs) >= k * GLYPH_W) begin
                slot_c = SLOT_W'(k);
                col_c  = COL_W'(int'(dxs) - k * GLYPH_W);
            end
        end
    end

    assign m0 = '{de: pixel_de_in, vs: pixel_vs_in, win: in_win, rgb: pixel_data_in};

    logic [CODE_W-1:0] char_buf [MAX_CHARS];
    logic [CODE_W-1:0] s1_code;
    logic [ROW_W-1:0]  s1_row;
    logic [COL_W-1:0]  s1_col;
    meta_t             m1;
    meta_t             m2;
    logic              glyph_bit;

    always_ff @(posedge pixel_clk) begin
        if (wr_en) begin
            char_buf[wr_addr] <= wr_code;
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            s1_code <= '0;
            s1_row  <= '0;
            s1_col  <= '0;
            m1      <= '0;
            m2      <= '0;
        end else begin
            s1_code <= char_buf[slot_c];
            s1_row  <= row_c;
            s1_col  <= col_c;
            m1      <= m0;
            m2      <= m1;
        end
    end

    glyph_rom #(
        .CODE_W (CODE_W)
    ) u_glyph_rom (
        .pixel_clk (pixel_clk),
        .rst       (rst),
        .code      (s1_code),
        .row       (s1_row),
        .col       (s1_col),
        .glyph_bit (glyph_bit)
    );

    // Colours and transparency are applied live at the output, not shadowed.
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            pixel_de_out   <= 1'b0;
            pixel_vs_out   <= 1'b0;
            front_de       <= 1'b0;
            pixel_data_out <= '0;
        end else begin
            pixel_de_out <= m2.de;
            pixel_vs_out <= m2.vs;
            front_de     <= m2.win;
            if (!m2.win) begin
                pixel_data_out <= m2.rgb;
            end else if (glyph_bit) begin
                pixel_data_out <= front_colour;
            end else begin
                pixel_data_out <= transparent ? m2.rgb : back_colour;
            end
        end
    end

endmodule
